// File: rtl/breakout_pkg.sv
// Shared playfield geometry, ball FSM states and direction encodings
// for the ball, bar and block modules.
package breakout_pkg;

    localparam int W_SCREEN = 640;
    localparam int H_SCREEN = 480;
    localparam int R_BALL   = 8;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LOST = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    // One step along an axis, clamped to [lo, hi] so the unsigned sum never wraps.
    function automatic logic [COORD_W-1:0] step_clamp(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] spd,
        input logic               inc,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        logic [COORD_W-1:0] result;
        if (inc) begin
            result = (pos >= hi - spd) ? hi : pos + spd;
        end else begin
            result = (pos <= lo + spd) ? lo : pos - spd;
        end
        return result;
    endfunction

endpackage

// File: rtl/ball_tick.sv
// Motion-step timer: counts 0..TICK_CYCLES-1 and pulses tick for one cycle
// at the wrap; a synchronous clear holds the count at zero.
module ball_tick #(
    parameter int TICK_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST) && !clear;

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction owner: steps once per tick, bounces off blocks, bar and walls.
// Define BALL_SPEEDUP_EN to raise the step size with the block-hit count.
module ball_motion #(
    parameter int W_SCREEN    = breakout_pkg::W_SCREEN,
    parameter int H_SCREEN    = breakout_pkg::H_SCREEN,
    parameter int R_BALL      = breakout_pkg::R_BALL,
    parameter int X_START     = 320,
    parameter int Y_START     = 400,
    parameter int TICK_CYCLES = 250000,
    parameter int COOLDOWN    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       hit_block_u,
    input  logic       hit_block_d,
    input  logic       hit_block_l,
    input  logic       hit_block_r,
    input  logic       hit_bar,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       lost,
    output logic [7:0] hits
);

    import breakout_pkg::*;

    localparam logic [9:0] X_MIN = 10'(R_BALL);
    localparam logic [9:0] X_MAX = 10'(W_SCREEN - 1 - R_BALL);
    localparam logic [9:0] Y_MIN = 10'(R_BALL);
    localparam logic [9:0] Y_MAX = 10'(H_SCREEN - 1 - R_BALL);
    localparam logic [9:0] X_INIT = 10'(X_START);
    localparam logic [9:0] Y_INIT = 10'(Y_START);
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    state_e          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic            dx_q, dx_d;
    logic            dy_q, dy_d;
    logic [7:0]      hits_q, hits_d;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic            tick;
    logic [9:0]      speed;
    logic            block_hit;
    logic            honour;

`ifdef BALL_SPEEDUP_EN
    logic [4:0] hits_div;
    always_comb begin
        hits_div = hits_q[7:3];
        speed    = (hits_div >= 5'd3) ? 10'd4 : 10'(hits_div) + 10'd1;
    end
`else
    assign speed = 10'd1;
`endif

    ball_tick #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (state_q != MOVE),
        .tick  (tick)
    );

    assign next_x = step_clamp(x_q, speed, dx_q, X_MIN, X_MAX);
    assign next_y = step_clamp(y_q, speed, dy_q, Y_MIN, Y_MAX);

    assign block_hit = hit_block_u | hit_block_d | hit_block_l | hit_block_r;
    assign honour    = block_hit && (cooldown_q == '0);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        hits_d     = hits_q;
        cooldown_d = cooldown_q;

        case (state_q)
            IDLE, LOST: begin
                if (start) begin
                    state_d    = MOVE;
                    x_d        = X_INIT;
                    y_d        = Y_INIT;
                    dx_d       = DIR_RIGHT;
                    dy_d       = DIR_UP;
                    hits_d     = '0;
                    cooldown_d = '0;
                end
            end
            MOVE: begin
                if (y_q >= Y_MAX) begin
                    state_d = LOST;
                end else begin
                    if (tick) begin
                        x_d = next_x;
                        y_d = next_y;
                        if (cooldown_q != '0) begin
                            cooldown_d = cooldown_q - CD_W'(1);
                        end
                    end
                    // Later assignments win: blocks, then bar, then walls.
                    if (honour) begin
                        if (hit_block_l) dx_d = DIR_LEFT;
                        if (hit_block_r) dx_d = DIR_RIGHT;
                        if (hit_block_d) dy_d = DIR_DOWN;
                        if (hit_block_u) dy_d = DIR_UP;
                        cooldown_d = CD_W'(COOLDOWN);
                        if (hits_q != 8'hFF) begin
                            hits_d = hits_q + 8'd1;
                        end
                    end
                    if (hit_bar) dy_d = DIR_UP;
                    if (x_q <= X_MIN) dx_d = DIR_RIGHT;
                    if (x_q >= X_MAX) dx_d = DIR_LEFT;
                    if (y_q <= Y_MIN) dy_d = DIR_DOWN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            x_q        <= X_INIT;
            y_q        <= Y_INIT;
            dx_q       <= DIR_RIGHT;
            dy_q       <= DIR_UP;
            hits_q     <= '0;
            cooldown_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            hits_q     <= hits_d;
            cooldown_q <= cooldown_d;
        end
    end

    assign x_ball = x_q;
    assign y_ball = y_q;
    assign dir_x  = dx_q;
    assign dir_y  = dy_q;
    assign hits   = hits_q;
    assign lost   = (state_q == LOST);

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion with a 4-cycle motion tick; expected values
// are queued as stimulus is driven and compared once the DUT has responded.
module tb_ball_motion;

    localparam int TICK = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       hit_block_u = 1'b0;
    logic       hit_block_d = 1'b0;
    logic       hit_block_l = 1'b0;
    logic       hit_block_r = 1'b0;
    logic       hit_bar = 1'b0;
    logic [9:0] x_ball, y_ball, next_x, next_y;
    logic       dir_x, dir_y, lost;
    logic [7:0] hits;

    always #5 clock = ~clock;

    ball_motion #(
        .TICK_CYCLES (TICK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .hit_block_u (hit_block_u),
        .hit_block_d (hit_block_d),
        .hit_block_l (hit_block_l),
        .hit_block_r (hit_block_r),
        .hit_bar     (hit_bar),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .next_x      (next_x),
        .next_y      (next_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .lost        (lost),
        .hits        (hits)
    );

    typedef enum int {S_X, S_Y, S_NX, S_NY, S_DX, S_DY, S_LOST, S_HITS} sig_e;
    typedef struct {
        string tag;
        sig_e  sig;
        int    value;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_value(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
            $display("[%0t] check %s: got %0d expected %0d ok", $time, tag, got, want);
        end else begin
            $display("[%0t] FAIL %s: got %0d expected %0d", $time, tag, got, want);
        end
    endtask

    function automatic int observe(input sig_e s);
        case (s)
            S_X:     return int'(x_ball);
            S_Y:     return int'(y_ball);
            S_NX:    return int'(next_x);
            S_NY:    return int'(next_y);
            S_DX:    return int'(dir_x);
            S_DY:    return int'(dir_y);
            S_LOST:  return int'(lost);
            S_HITS:  return int'(hits);
            default: return -1;
        endcase
    endfunction

    task automatic push_exp(input string tag, input sig_e s, input int v);
        exp_t e;
        e.tag   = tag;
        e.sig   = s;
        e.value = v;
        sb_q.push_back(e);
    endtask

    task automatic push_pos(input string tag, input int x, input int y, input int nx, input int ny);
        push_exp({tag, "_x"}, S_X, x);
        push_exp({tag, "_y"}, S_Y, y);
        push_exp({tag, "_nx"}, S_NX, nx);
        push_exp({tag, "_ny"}, S_NY, ny);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_value(e.tag, observe(e.sig), e.value);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // Reset, then idle with start low.
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycles(5);
            push_exp($sformatf("idle%0d_x", i), S_X, 320);
            push_exp($sformatf("idle%0d_y", i), S_Y, 400);
            push_exp($sformatf("idle%0d_dx", i), S_DX, 1);
            push_exp($sformatf("idle%0d_dy", i), S_DY, 0);
            push_exp($sformatf("idle%0d_lost", i), S_LOST, 0);
            drain();
        end

        // Launch: first step lands TICK cycles after entering MOVE.
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(3);
        push_exp("pre_step_x", S_X, 320);
        drain();
        cycles(1);
        push_pos("step1", 321, 399, 322, 398);
        drain();
        cycles(8);
        push_pos("step3", 323, 397, 324, 396);
        push_exp("step3_hits", S_HITS, 0);
        drain();

        // Right wall at x=631 (step 311).
        cycles(1232);
        push_pos("wall_r", 631, 89, 631, 88);
        push_exp("wall_r_dx_before", S_DX, 1);
        drain();
        cycles(1);
        push_exp("wall_r_dx_after", S_DX, 0);
        push_exp("wall_r_nx_after", S_NX, 630);
        drain();
        cycles(3);
        push_exp("wall_r_step_x", S_X, 630);
        push_exp("wall_r_step_y", S_Y, 88);
        drain();

        // Block hits and cooldown.
        hit_block_u = 1'b1;
        cycles(1);
        hit_block_u = 1'b0;
        push_exp("blk_u_dy", S_DY, 0);
        push_exp("blk_u_hits", S_HITS, 1);
        drain();
        cycles(11);
        hit_block_d = 1'b1;
        cycles(1);
        hit_block_d = 1'b0;
        push_exp("cool_d_dy", S_DY, 0);
        push_exp("cool_d_hits", S_HITS, 1);
        drain();
        cycles(3);
        hit_block_d = 1'b1;
        cycles(1);
        hit_block_d = 1'b0;
        push_exp("blk_d_dy", S_DY, 1);
        push_exp("blk_d_hits", S_HITS, 2);
        drain();
        hit_block_r = 1'b1;
        cycles(1);
        hit_block_r = 1'b0;
        push_exp("cool_r_dx", S_DX, 0);
        push_exp("cool_r_hits", S_HITS, 2);
        push_exp("cool_r_x", S_X, 626);
        push_exp("cool_r_y", S_Y, 84);
        drain();

        // Bar together with block bottom: bar wins on dir_y, block still counted.
        cycles(14);
        hit_bar = 1'b1;
        hit_block_d = 1'b1;
        cycles(1);
        hit_bar = 1'b0;
        hit_block_d = 1'b0;
        push_exp("bar_d_dy", S_DY, 0);
        push_exp("bar_d_hits", S_HITS, 3);
        push_exp("bar_d_x", S_X, 622);
        push_exp("bar_d_y", S_Y, 88);
        drain();

        // Top wall at y=8 (step 400).
        cycles(319);
        push_pos("wall_t", 542, 8, 541, 8);
        push_exp("wall_t_dy_before", S_DY, 0);
        drain();
        cycles(1);
        push_exp("wall_t_dy_after", S_DY, 1);
        push_exp("wall_t_ny_after", S_NY, 9);
        drain();

        // Bottom edge at y=471 (step 863) -> LOST.
        cycles(1851);
        push_exp("bottom_y", S_Y, 471);
        push_exp("bottom_x", S_X, 79);
        push_exp("bottom_lost_pre", S_LOST, 0);
        drain();
        cycles(1);
        push_exp("lost_set", S_LOST, 1);
        drain();
        hit_block_r = 1'b1;
        hit_bar = 1'b1;
        cycles(10);
        hit_block_r = 1'b0;
        hit_bar = 1'b0;
        push_exp("lost_frozen_x", S_X, 79);
        push_exp("lost_frozen_y", S_Y, 471);
        push_exp("lost_hold", S_LOST, 1);
        push_exp("lost_dx", S_DX, 0);
        push_exp("lost_dy", S_DY, 1);
        push_exp("lost_hits", S_HITS, 3);
        drain();

        // Relaunch from LOST.
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        push_pos("relaunch", 320, 400, 321, 399);
        push_exp("relaunch_hits", S_HITS, 0);
        push_exp("relaunch_lost", S_LOST, 0);
        push_exp("relaunch_dx", S_DX, 1);
        push_exp("relaunch_dy", S_DY, 0);
        drain();
        cycles(3);
        push_exp("relaunch_pre_step_x", S_X, 320);
        drain();
        cycles(1);
        push_exp("relaunch_step_x", S_X, 321);
        push_exp("relaunch_step_y", S_Y, 399);
        drain();

        // Asynchronous reset in the middle of a tick period.
        cycles(1);
        #2;
        reset = 1'b0;
        #1;
        push_pos("async_rst", 320, 400, 321, 399);
        push_exp("async_rst_dx", S_DX, 1);
        push_exp("async_rst_dy", S_DY, 0);
        push_exp("async_rst_lost", S_LOST, 0);
        push_exp("async_rst_hits", S_HITS, 0);
        drain();
        @(negedge clock);
        reset = 1'b1;
        cycles(12);
        push_exp("post_rst_idle_x", S_X, 320);
        push_exp("post_rst_idle_y", S_Y, 400);
        drain();

`ifdef BALL_SPEEDUP_EN
        // One honoured hit every 16 cycles; speed tracks hits >> 3.
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        for (int j = 0; j < 32; j++) begin
            hit_block_u = 1'b1;
            cycles(1);
            hit_block_u = 1'b0;
            if (j == 7) begin
                push_pos("speed2", 348, 372, 350, 370);
                push_exp("speed2_hits", S_HITS, 8);
                drain();
            end
            if (j == 31) begin
                push_pos("speed4", 627, 84, 623, 80);
                push_exp("speed4_hits", S_HITS, 32);
                push_exp("speed4_dx", S_DX, 0);
                drain();
            end else begin
                cycles(15);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
